// File: rtl/jtkcpu_regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtkcpu_regs_pkg                                        |
// | Description : KCPU register codes, CC bits, PSH/PUL mask bit order   |
// |               and register-bank helper functions.                    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package jtkcpu_regs_pkg;

    localparam logic [3:0] c_REG_D  = 4'h0;
    localparam logic [3:0] c_REG_X  = 4'h1;
    localparam logic [3:0] c_REG_Y  = 4'h2;
    localparam logic [3:0] c_REG_U  = 4'h3;
    localparam logic [3:0] c_REG_S  = 4'h4;
    localparam logic [3:0] c_REG_A  = 4'h8;
    localparam logic [3:0] c_REG_B  = 4'h9;
    localparam logic [3:0] c_REG_CC = 4'hA;
    localparam logic [3:0] c_REG_DP = 4'hB;

    localparam int c_CC_C = 0;
    localparam int c_CC_V = 1;
    localparam int c_CC_Z = 2;
    localparam int c_CC_N = 3;
    localparam int c_CC_I = 4;
    localparam int c_CC_H = 5;
    localparam int c_CC_F = 6;
    localparam int c_CC_E = 7;

    // PSH walks these from 7 down to 0, PUL from 0 up to 7
    localparam logic [2:0] c_MB_CC = 3'd0;
    localparam logic [2:0] c_MB_A  = 3'd1;
    localparam logic [2:0] c_MB_B  = 3'd2;
    localparam logic [2:0] c_MB_DP = 3'd3;
    localparam logic [2:0] c_MB_X  = 3'd4;
    localparam logic [2:0] c_MB_Y  = 3'd5;
    localparam logic [2:0] c_MB_SU = 3'd6;
    localparam logic [2:0] c_MB_PC = 3'd7;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] u;
        logic [15:0] s;
        logic [7:0]  dp;
        logic [7:0]  cc;
    } regs_t;

    function automatic logic is8(logic [3:0] code);
        return code[3] & ~code[2];
    endfunction

    function automatic logic [15:0] read_reg(regs_t r, logic [3:0] code);
        logic [15:0] v;
        case (code)
            c_REG_D:  v = {r.a, r.b};
            c_REG_X:  v = r.x;
            c_REG_Y:  v = r.y;
            c_REG_U:  v = r.u;
            c_REG_S:  v = r.s;
            c_REG_A:  v = {8'h00, r.a};
            c_REG_B:  v = {8'h00, r.b};
            c_REG_CC: v = {8'h00, r.cc};
            c_REG_DP: v = {8'h00, r.dp};
            default:  v = 16'h0000;
        endcase
        return v;
    endfunction

    function automatic regs_t write_reg(regs_t r, logic [3:0] code, logic [15:0] d);
        regs_t n;
        n = r;
        case (code)
            c_REG_D:  begin n.a = d[15:8]; n.b = d[7:0]; end
            c_REG_X:  n.x  = d;
            c_REG_Y:  n.y  = d;
            c_REG_U:  n.u  = d;
            c_REG_S:  n.s  = d;
            c_REG_A:  n.a  = d[7:0];
            c_REG_B:  n.b  = d[7:0];
            c_REG_CC: n.cc = d[7:0];
            c_REG_DP: n.dp = d[7:0];
            default:  ;
        endcase
        return n;
    endfunction

    function automatic regs_t write_byte(regs_t r, logic [3:0] code, logic hi, logic [7:0] d);
        regs_t n;
        n = r;
        case (code)
            c_REG_D:  if (hi) n.a = d; else n.b = d;
            c_REG_X:  if (hi) n.x[15:8] = d; else n.x[7:0] = d;
            c_REG_Y:  if (hi) n.y[15:8] = d; else n.y[7:0] = d;
            c_REG_U:  if (hi) n.u[15:8] = d; else n.u[7:0] = d;
            c_REG_S:  if (hi) n.s[15:8] = d; else n.s[7:0] = d;
            c_REG_A:  n.a  = d;
            c_REG_B:  n.b  = d;
            c_REG_CC: n.cc = d;
            c_REG_DP: n.dp = d;
            default:  ;
        endcase
        return n;
    endfunction

    // Value an EXG/TFR source delivers to its destination: 8-bit into 16-bit pads with FF
    function automatic logic [15:0] xfer_val(logic [3:0] src, logic [15:0] v, logic [3:0] dst);
        return (is8(src) && !is8(dst)) ? {8'hFF, v[7:0]} : v;
    endfunction

    function automatic logic [2:0] msb_idx(logic [7:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) k = i[2:0];
        return k;
    endfunction

    function automatic logic [2:0] lsb_idx(logic [7:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) k = i[2:0];
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtkcpu_regs_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtkcpu_regs_stack                                      |
// | Description : Byte-serial PSH/PUL sequencer with req/ack stack bus.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module jtkcpu_regs_stack
    import jtkcpu_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        psh,
    input  logic        pul,
    input  logic        stk_u,
    input  logic [7:0]  mask,
    input  logic [15:0] pc_in,
    input  regs_t       regs,
    output logic        busy,
    output logic        done,
    output logic [15:0] pc_out,
    output logic        pc_we,
    output logic        stk_req,
    input  logic        stk_ack,
    output logic        stk_we,
    output logic [15:0] stk_addr,
    output logic [7:0]  stk_dout,
    input  logic [7:0]  stk_din,
    output logic        wb_en,
    output logic [3:0]  wb_sel,
    output logic        wb_hi,
    output logic [7:0]  wb_data,
    output logic        ptr_we,
    output logic [3:0]  ptr_sel,
    output logic [15:0] ptr_val
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEL  = 2'd1;
    localparam logic [1:0] c_ST_XFER = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_mask;
    logic        r_psh;
    logic        r_use_u;
    logic [2:0]  r_bit;
    logic        r_second;
    logic [15:0] r_pc;
    logic [15:0] r_pc_out;
    logic        r_pc_we;

    logic [15:0] w_ptr;
    logic [15:0] w_word;
    logic        w_hi;
    logic        w_fin;

    assign w_ptr   = r_use_u ? regs.u : regs.s;
    assign ptr_sel = r_use_u ? c_REG_U : c_REG_S;
    // Push moves the low byte of a 16-bit register first, pull the high byte first
    assign w_hi    = r_bit[2] & (r_psh ? r_second : ~r_second);
    assign w_fin   = (r_state == c_ST_XFER) & stk_ack & cen;

    always_comb begin
        w_word = 16'h0000;
        wb_sel = c_REG_CC;
        case (r_bit)
            c_MB_PC: begin w_word = r_pc;                       wb_sel = c_REG_D; end
            c_MB_SU: begin w_word = r_use_u ? regs.s : regs.u;  wb_sel = r_use_u ? c_REG_S : c_REG_U; end
            c_MB_Y:  begin w_word = regs.y;                     wb_sel = c_REG_Y; end
            c_MB_X:  begin w_word = regs.x;                     wb_sel = c_REG_X; end
            c_MB_DP: begin w_word = {8'h00, regs.dp};           wb_sel = c_REG_DP; end
            c_MB_B:  begin w_word = {8'h00, regs.b};            wb_sel = c_REG_B; end
            c_MB_A:  begin w_word = {8'h00, regs.a};            wb_sel = c_REG_A; end
            default: begin w_word = {8'h00, regs.cc};           wb_sel = c_REG_CC; end
        endcase
    end

    assign stk_req  = (r_state == c_ST_XFER);
    assign stk_we   = stk_req & r_psh;
    assign stk_addr = r_psh ? w_ptr - 16'd1 : w_ptr;
    assign stk_dout = w_hi ? w_word[15:8] : w_word[7:0];

    assign ptr_we   = w_fin;
    assign ptr_val  = r_psh ? w_ptr - 16'd1 : w_ptr + 16'd1;
    assign wb_en    = w_fin & ~r_psh & (r_bit != c_MB_PC);
    assign wb_hi    = w_hi;
    assign wb_data  = stk_din;

    assign busy   = (r_state == c_ST_SEL) | (r_state == c_ST_XFER);
    assign done   = (r_state == c_ST_DONE);
    assign pc_out = r_pc_out;
    assign pc_we  = r_pc_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_mask   <= 8'h00;
            r_psh    <= 1'b0;
            r_use_u  <= 1'b0;
            r_bit    <= 3'd0;
            r_second <= 1'b0;
            r_pc     <= 16'h0000;
            r_pc_out <= 16'h0000;
            r_pc_we  <= 1'b0;
        end else if (cen) begin
            r_pc_we <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (psh || pul) begin
                        r_mask   <= mask;
                        r_psh    <= psh;
                        r_use_u  <= stk_u;
                        r_pc     <= pc_in;
                        r_second <= 1'b0;
                        r_state  <= (mask == 8'h00) ? c_ST_DONE : c_ST_SEL;
                    end else begin
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_SEL: begin
                    if (r_mask == 8'h00) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_bit   <= r_psh ? msb_idx(r_mask) : lsb_idx(r_mask);
                        r_state <= c_ST_XFER;
                    end
                end
                default: begin
                    if (stk_ack) begin
                        if (r_bit[2] && !r_second) begin
                            r_second <= 1'b1;
                        end else begin
                            r_second      <= 1'b0;
                            r_mask[r_bit] <= 1'b0;
                        end
                        if (!r_psh && r_bit == c_MB_PC) begin
                            if (w_hi) begin
                                r_pc_out[15:8] <= stk_din;
                            end else begin
                                r_pc_out[7:0]  <= stk_din;
                                r_pc_we        <= 1'b1;
                            end
                        end
                        r_state <= c_ST_SEL;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtkcpu_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtkcpu_regs                                            |
// | Description : KCPU programmer-visible register bank with two read    |
// |               ports, two write ports, EXG/TFR and PSH/PUL sequencer. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module jtkcpu_regs
    import jtkcpu_regs_pkg::*;
#(
    parameter logic [7:0] CC_RST = 8'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [3:0]  rd0_sel,
    input  logic [3:0]  rd1_sel,
    output logic [15:0] rd0,
    output logic [15:0] rd1,
    input  logic        wr_en,
    input  logic [3:0]  wr_sel,
    input  logic [15:0] wr_data,
    input  logic        wr2_en,
    input  logic [3:0]  wr2_sel,
    input  logic [15:0] wr2_data,
    input  logic        cc_we,
    input  logic [7:0]  cc_in,
    output logic [7:0]  cc,
    output logic [7:0]  dp,
    input  logic        exg_en,
    input  logic        tfr,
    input  logic [7:0]  post,
    input  logic        psh,
    input  logic        pul,
    input  logic        stk_u,
    input  logic [7:0]  mask,
    input  logic [15:0] pc_in,
    output logic [15:0] pc_out,
    output logic        pc_we,
    output logic        stk_busy,
    output logic        stk_done,
    output logic        stk_req,
    input  logic        stk_ack,
    output logic        stk_we,
    output logic [15:0] stk_addr,
    output logic [7:0]  stk_dout,
    input  logic [7:0]  stk_din
);

    regs_t       r_regs;
    regs_t       w_nxt;

    logic [3:0]  w_src;
    logic [3:0]  w_dst;
    logic [15:0] w_src_val;
    logic [15:0] w_dst_val;

    logic        w_wb_en;
    logic [3:0]  w_wb_sel;
    logic        w_wb_hi;
    logic [7:0]  w_wb_data;
    logic        w_ptr_we;
    logic [3:0]  w_ptr_sel;
    logic [15:0] w_ptr_val;

    assign w_src     = post[7:4];
    assign w_dst     = post[3:0];
    assign w_src_val = read_reg(r_regs, w_src);
    assign w_dst_val = read_reg(r_regs, w_dst);

    // Lowest priority applied first so later writes override per byte
    always_comb begin
        w_nxt = r_regs;
        if (!stk_busy) begin
            if (cc_we)  w_nxt.cc = cc_in;
            if (wr_en)  w_nxt = write_reg(w_nxt, wr_sel, wr_data);
            if (wr2_en) w_nxt = write_reg(w_nxt, wr2_sel, wr2_data);
            if (exg_en) begin
                if (!tfr) w_nxt = write_reg(w_nxt, w_src, xfer_val(w_dst, w_dst_val, w_src));
                w_nxt = write_reg(w_nxt, w_dst, xfer_val(w_src, w_src_val, w_dst));
            end
        end
        if (w_wb_en)  w_nxt = write_byte(w_nxt, w_wb_sel, w_wb_hi, w_wb_data);
        if (w_ptr_we) w_nxt = write_reg(w_nxt, w_ptr_sel, w_ptr_val);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_regs <= '{cc: CC_RST, default: '0};
        else if (cen)
            r_regs <= w_nxt;
    end

    assign rd0 = read_reg(r_regs, rd0_sel);
    assign rd1 = read_reg(r_regs, rd1_sel);
    assign cc  = r_regs.cc;
    assign dp  = r_regs.dp;

    jtkcpu_regs_stack u_stack (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .psh      (psh),
        .pul      (pul),
        .stk_u    (stk_u),
        .mask     (mask),
        .pc_in    (pc_in),
        .regs     (r_regs),
        .busy     (stk_busy),
        .done     (stk_done),
        .pc_out   (pc_out),
        .pc_we    (pc_we),
        .stk_req  (stk_req),
        .stk_ack  (stk_ack),
        .stk_we   (stk_we),
        .stk_addr (stk_addr),
        .stk_dout (stk_dout),
        .stk_din  (stk_din),
        .wb_en    (w_wb_en),
        .wb_sel   (w_wb_sel),
        .wb_hi    (w_wb_hi),
        .wb_data  (w_wb_data),
        .ptr_we   (w_ptr_we),
        .ptr_sel  (w_ptr_sel),
        .ptr_val  (w_ptr_val)
    );

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_jtkcpu_regs                                         |
// | Description : Scoreboard bench for jtkcpu_regs with stack-bus model. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_jtkcpu_regs;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [3:0]  rd0_sel, rd1_sel;
    logic [15:0] rd0, rd1;
    logic        wr_en, wr2_en, cc_we, exg_en, tfr, psh, pul, stk_u;
    logic [3:0]  wr_sel, wr2_sel;
    logic [15:0] wr_data, wr2_data, pc_in, pc_out, stk_addr;
    logic [7:0]  cc_in, cc, dp, post, mask, stk_dout, stk_din;
    logic        pc_we, stk_busy, stk_done, stk_req, stk_ack, stk_we;

    typedef struct { string name; int port; logic [15:0] exp; } rchk_t;
    typedef struct { logic [15:0] addr; logic we; logic [7:0] data; } bus_t;

    rchk_t       q_reg[$];
    bus_t        q_bus[$];
    logic [15:0] q_pc[$];
    logic [7:0]  mem [0:255];

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    int          n_grants = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        chk_v = 1'b0;
    logic [15:0] lat_addr;
    logic [7:0]  lat_dout;
    logic        lat_we;

    always #5 clk = ~clk;

    jtkcpu_regs #(.CC_RST(8'h50)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .rd0_sel(rd0_sel), .rd1_sel(rd1_sel), .rd0(rd0), .rd1(rd1),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr2_en(wr2_en), .wr2_sel(wr2_sel), .wr2_data(wr2_data),
        .cc_we(cc_we), .cc_in(cc_in), .cc(cc), .dp(dp),
        .exg_en(exg_en), .tfr(tfr), .post(post),
        .psh(psh), .pul(pul), .stk_u(stk_u), .mask(mask),
        .pc_in(pc_in), .pc_out(pc_out), .pc_we(pc_we),
        .stk_busy(stk_busy), .stk_done(stk_done),
        .stk_req(stk_req), .stk_ack(stk_ack), .stk_we(stk_we),
        .stk_addr(stk_addr), .stk_dout(stk_dout), .stk_din(stk_din)
    );

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor and stack-memory responder, both sampling on the falling edge
    always @(negedge clk) begin
        if (chk_v) begin
            if (q_reg.size() == 0) begin
                check("reg queue underflow", 16'h0001, 16'h0000);
            end else begin
                rchk_t it;
                logic [15:0] act;
                it = q_reg.pop_front();
                case (it.port)
                    0: act = rd0;
                    1: act = rd1;
                    2: act = {8'h00, cc};
                    3: act = {8'h00, dp};
                    4: act = {15'h0, stk_req};
                    default: act = {15'h0, stk_busy};
                endcase
                check(it.name, act, it.exp);
            end
        end
        if (pc_we) begin
            if (q_pc.size() == 0) check("unexpected pc_we", pc_out, 16'hxxxx);
            else check("pulled pc", pc_out, q_pc.pop_front());
        end
        if (stk_done) n_done++;

        if (stk_req) begin
            if (wcnt == 0) begin
                lat_addr = stk_addr; lat_we = stk_we; lat_dout = stk_dout;
            end else begin
                check("req addr stable", stk_addr, lat_addr);
                check("req we/dout stable", {7'h0, stk_we, stk_dout}, {7'h0, lat_we, lat_dout});
            end
            if (wcnt >= ack_delay) begin
                stk_ack = 1'b1;
                wcnt = 0;
                n_grants++;
                if (q_bus.size() == 0) begin
                    check("unexpected bus cycle", stk_addr, 16'hxxxx);
                end else begin
                    bus_t b;
                    b = q_bus.pop_front();
                    check("bus addr", stk_addr, b.addr);
                    check("bus we", {15'h0, stk_we}, {15'h0, b.we});
                    if (b.we) check("bus wdata", {8'h00, stk_dout}, {8'h00, b.data});
                end
                if (stk_we) mem[stk_addr[7:0]] = stk_dout;
                else        stk_din = mem[stk_addr[7:0]];
            end else begin
                stk_ack = 1'b0;
                wcnt++;
            end
        end else begin
            stk_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(string name, int port, logic [3:0] sel, logic [15:0] exp);
        if (port == 0) rd0_sel = sel;
        if (port == 1) rd1_sel = sel;
        q_reg.push_back('{name, port, exp});
        chk_v = 1'b1;
        step();
        chk_v = 1'b0;
    endtask

    task automatic wr(logic [3:0] sel, logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic exg(logic t, logic [7:0] pb);
        exg_en = 1'b1; tfr = t; post = pb;
        step();
        exg_en = 1'b0;
    endtask

    task automatic wait_done(string name);
        for (int k = 0; k < 300 && !stk_done; k++) step();
        check(name, {15'h0, stk_done}, 16'h0001);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cen = 1'b1; rd0_sel = 4'h0; rd1_sel = 4'h0;
        wr_en = 1'b0; wr_sel = 4'h0; wr_data = 16'h0;
        wr2_en = 1'b0; wr2_sel = 4'h0; wr2_data = 16'h0;
        cc_we = 1'b0; cc_in = 8'h00; exg_en = 1'b0; tfr = 1'b0; post = 8'h00;
        psh = 1'b0; pul = 1'b0; stk_u = 1'b0; mask = 8'h00; pc_in = 16'h0;
        stk_ack = 1'b0; stk_din = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst D", 0, 4'h0, 16'h0000);
        chk("rst X", 0, 4'h1, 16'h0000);
        chk("rst Y", 0, 4'h2, 16'h0000);
        chk("rst U", 0, 4'h3, 16'h0000);
        chk("rst S", 0, 4'h4, 16'h0000);
        chk("rst A", 0, 4'h8, 16'h0000);
        chk("rst B", 0, 4'h9, 16'h0000);
        chk("rst DP", 0, 4'hB, 16'h0000);
        chk("rst CC rd1", 1, 4'hA, 16'h0050);
        chk("rst cc port", 2, 4'h0, 16'h0050);
        chk("rst stk_req", 4, 4'h0, 16'h0000);

        // Basic writes and transfers
        wr(4'h0, 16'h1234);
        chk("wr D -> A", 0, 4'h8, 16'h0012);
        chk("wr D -> B", 1, 4'h9, 16'h0034);
        chk("wr D -> D", 0, 4'h0, 16'h1234);
        exg(1'b1, 8'h89);
        chk("TFR A,B", 0, 4'h9, 16'h0012);
        wr(4'h1, 16'hABCD);
        exg(1'b0, 8'h81);
        chk("EXG A,X -> A", 0, 4'h8, 16'h00CD);
        chk("EXG A,X -> X", 1, 4'h1, 16'hFF12);

        // Write priorities
        cc_we = 1'b1; cc_in = 8'h0F; step(); cc_we = 1'b0;
        chk("cc_we alone", 2, 4'h0, 16'h000F);
        cc_we = 1'b1; cc_in = 8'h0F; wr(4'hA, 16'h0055); cc_we = 1'b0;
        chk("wr CC beats cc_we", 2, 4'h0, 16'h0055);
        wr2_en = 1'b1; wr2_sel = 4'h1; wr2_data = 16'h2222;
        wr(4'h1, 16'h1111); wr2_en = 1'b0;
        chk("wr2 beats wr", 0, 4'h1, 16'h2222);
        cen = 1'b0; wr(4'h1, 16'h3333); cen = 1'b1;
        chk("cen=0 holds X", 0, 4'h1, 16'h2222);
        wr2_en = 1'b1; wr2_sel = 4'h8; wr2_data = 16'h0077;
        wr(4'h0, 16'hAAAA); wr2_en = 1'b0;
        chk("per-byte D vs A", 0, 4'h0, 16'h77AA);
        wr(4'hB, 16'h0042);
        chk("DP port", 3, 4'h0, 16'h0042);
        exg(1'b0, 8'h11);
        chk("EXG X,X unchanged", 0, 4'h1, 16'h2222);

        // Push PC,B,A onto S
        wr(4'h0, 16'h0102);
        wr(4'h4, 16'h0100);
        ack_delay = 0;
        q_bus.push_back('{16'h00FF, 1'b1, 8'hEF});
        q_bus.push_back('{16'h00FE, 1'b1, 8'hBE});
        q_bus.push_back('{16'h00FD, 1'b1, 8'h02});
        q_bus.push_back('{16'h00FC, 1'b1, 8'h01});
        psh = 1'b1; stk_u = 1'b0; mask = 8'h86; pc_in = 16'hBEEF;
        step(); psh = 1'b0;
        wr_en = 1'b1; wr_sel = 4'h1; wr_data = 16'h5555;
        chk("busy during push", 5, 4'h0, 16'h0001);
        wr_en = 1'b0;
        wait_done("push done");
        chk("push S", 0, 4'h4, 16'h00FC);
        chk("wr ignored while busy", 0, 4'h1, 16'h2222);

        // Pull the same frame with slow acks
        wr(4'h0, 16'h0000);
        chk("D cleared", 0, 4'h0, 16'h0000);
        ack_delay = 3;
        q_bus.push_back('{16'h00FC, 1'b0, 8'h00});
        q_bus.push_back('{16'h00FD, 1'b0, 8'h00});
        q_bus.push_back('{16'h00FE, 1'b0, 8'h00});
        q_bus.push_back('{16'h00FF, 1'b0, 8'h00});
        q_pc.push_back(16'hBEEF);
        pul = 1'b1; mask = 8'h86; pc_in = 16'h0000;
        step(); pul = 1'b0;
        wait_done("pull done");
        chk("pull A", 0, 4'h8, 16'h0001);
        chk("pull B", 0, 4'h9, 16'h0002);
        chk("pull S", 0, 4'h4, 16'h0100);

        // Reset during the second byte of a push
        ack_delay = 4;
        q_bus.push_back('{16'h00FF, 1'b1, 8'h02});
        begin
            int g0;
            g0 = n_grants;
            psh = 1'b1; mask = 8'h06;
            step(); psh = 1'b0;
            for (int k = 0; k < 100 && !(n_grants == g0 + 1 && stk_req); k++) step();
            check("second byte reached", {15'h0, stk_req}, 16'h0001);
        end
        rst = 1'b1; step(); rst = 1'b0;
        chk("req dropped on rst", 4, 4'h0, 16'h0000);
        chk("S reset", 0, 4'h4, 16'h0000);
        chk("CC reset", 2, 4'h0, 16'h0050);

        // Empty mask: done pulse, no bus cycle, never busy
        psh = 1'b1; mask = 8'h00;
        step(); psh = 1'b0;
        check("mask0 done", {15'h0, stk_done}, 16'h0001);
        chk("mask0 not busy", 5, 4'h0, 16'h0000);
        chk("mask0 no req", 4, 4'h0, 16'h0000);
        step(); step();

        check("done pulse count", 16'(n_done), 16'd3);
        check("bus queue drained", 16'(q_bus.size()), 16'd0);
        check("pc queue drained", 16'(q_pc.size()), 16'd0);
        check("reg queue drained", 16'(q_reg.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtkcpu_regs.md
Name: jtkcpu_regs

Overview:
- Programmer-visible register bank of the KCPU: A, B (D = {A,B}), X, Y, U, S, DP and CC.
- Sits directly downstream of the ALU. Consumes its primary result, high result (LMUL/DIVXB) and updated flags.
- Feeds the ALU operand mux through two read ports.
- Contains the byte-serial PSH/PUL sequencer that moves registers to and from the stack over a req/ack memory handshake.

Parameters:
- CC_RST, 8'h50, CC value after reset (I and F set).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only when cen=1
- rd0_sel  in  4  register code for rd0
- rd1_sel  in  4  register code for rd1
- rd0  out  16  read data, combinational
- rd1  out  16  read data, combinational
- wr_en  in  1  write port 1 strobe
- wr_sel  in  4  write port 1 destination code
- wr_data  in  16  write port 1 data (ALU rslt)
- wr2_en  in  1  write port 2 strobe
- wr2_sel  in  4  write port 2 destination code
- wr2_data  in  16  write port 2 data (ALU rslt_hi)
- cc_we  in  1  load CC from cc_in
- cc_in  in  8  ALU flag output
- cc  out  8  current CC
- dp  out  8  current DP
- exg_en  in  1  execute EXG/TFR
- tfr  in  1  1=TFR (copy), 0=EXG (swap)
- post  in  8  EXG/TFR postbyte: [7:4] source, [3:0] destination
- psh  in  1  start push, one-cycle strobe
- pul  in  1  start pull, one-cycle strobe
- stk_u  in  1  1=use U as pointer and S as the "other" stack register; 0=the reverse
- mask  in  8  PSH/PUL register mask
- pc_in  in  16  PC value to push
- pc_out  out  16  pulled PC
- pc_we  out  1  one-cycle strobe when pc_out is valid
- stk_busy  out  1  sequencer active
- stk_done  out  1  one-cycle completion strobe
- stk_req  out  1  memory request
- stk_ack  in  1  memory acknowledge
- stk_we  out  1  1=write cycle
- stk_addr  out  16  memory address
- stk_dout  out  8  write data
- stk_din  in  8  read data

Behaviour:
- Register codes: 0=D, 1=X, 2=Y, 3=U, 4=S, 8=A, 9=B, A=CC, B=DP. All other codes read 16'h0000 and ignore writes.
- Reads of 8-bit codes return {8'h00, reg}.
- Reset: A, B, X, Y, U, S, DP = 0; CC = CC_RST; sequencer IDLE; stk_req, stk_we, pc_we, stk_done, stk_busy = 0.
- Writes take effect at the next cen edge.
  - 8-bit destinations take data[7:0].
  - Write priority, same target: exg > wr2 > wr > cc_we. An explicit write to CC beats cc_we.
  - Writes to D vs A/B targets are resolved per byte with the same priority.
- EXG/TFR, single cen cycle:
  - 16-bit to 8-bit transfers the low byte.
  - 8-bit to 16-bit writes {8'hFF, src}.
  - An invalid code on either side makes that side a no-op.
  - EXG with identical codes leaves the register unchanged.
- While stk_busy=1: wr_en, wr2_en, exg_en, psh and pul are ignored, and cc_we is ignored. CC is owned by the sequencer during pulls.
- Sequencer FSM: IDLE -> SEL -> XFER -> SEL ... -> DONE -> IDLE.
  - A start strobe latches mask and direction, then enters SEL.
  - mask==0: no bus cycle; stk_done pulses on the next cen cycle; stk_busy stays 0.
  - Push order is mask bit 7..0: PC, U/S, Y, X, DP, B, A, CC.
  - Push: each byte pre-decrements the pointer by 1, then writes. 16-bit registers go low byte first, then high.
  - Pull order is bit 0..7: CC first. Each byte reads at the pointer, then post-increments. 16-bit registers go high byte first.
  - In XFER, stk_req stays high (stk_addr/stk_dout/stk_we stable) until stk_ack is sampled high with cen. Then the byte completes and the FSM returns to SEL.
  - Pointer register is updated per byte, so a reset mid-sequence leaves no partial pointer shadow.
  - Pulled PC: pc_out is valid with a one-cycle pc_we after its low byte.
  - Pulled CC takes effect as soon as its byte completes.
  - DONE: stk_done=1 for one cen cycle; stk_busy drops the same cycle.
  - Maximum 12 bytes per instruction.
- rst mid-sequence: immediate return to IDLE with stk_req=0. Registers take their reset values.

Decomposition:
- Shared package/include (jtkcpu.inc): register-code constants, CC bit indices, mask bit order.
- Natural sub-module: jtkcpu_stack, the PSH/PUL FSM plus pointer/byte-select logic. It drives byte write requests back into the bank and holds the stack-bus ports.

Test Plan:
- Reset with rst=1 for 2 cycles -> rd of every code 0; cc=8'h50; stk_req=0.
- wr_en, wr_sel=0, wr_data=16'h1234 -> A=12, B=34. Then TFR post=8'h89 -> B=12. EXG post=8'h81 (A, X) with X=16'hABCD -> A=CD, X=16'hFF12.
- Simultaneous wr_sel=A with 16'h0055 and cc_we with 8'h0F -> CC=55. Simultaneous wr and wr2 to X -> wr2_data wins.
- S=16'h0100, psh with stk_u=0, mask=8'h86, pc_in=16'hBEEF, A=1, B=2 -> writes in order: 00FF=EF, 00FE=BE, 00FD=02, 00FC=01; S=00FC; one stk_done pulse.
- Pull the same frame with ack delayed 3 cycles per byte -> A=1, B=2, pc_out=BEEF with pc_we; S=0100; req held stable during waits.
- rst during the 2nd byte of a push -> stk_req=0 next cycle; S=0; a following psh with mask=0 -> stk_done pulse, no req.
